// File: rtl/pc_pkg.sv
//============================================================================
// Module      : pc_pkg
// Description : Shared constants and enumerations for the next-PC generator.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package pc_pkg;

    localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;
    localparam int unsigned PC_INC               = 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_RESET     = 3'd0,
        SEL_HOLD      = 3'd1,
        SEL_RET       = 3'd2,
        SEL_RET_EMPTY = 3'd3,
        SEL_CALL      = 3'd4,
        SEL_JUMP      = 3'd5,
        SEL_BRANCH    = 3'd6,
        SEL_INC       = 3'd7
    } pc_sel_t;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
//============================================================================
// Module      : ras_stack
// Description : Circular return-address stack; a push when full drops the
//               oldest entry, a pop when empty leaves the stack untouched.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow_evt,
    output logic             underflow_evt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;

    // r_ptr addresses the newest entry; wrap-around relies on DEPTH being a power of two
    assign w_ptr_inc     = r_ptr + PTR_W'(1);
    assign w_ptr_dec     = r_ptr - PTR_W'(1);
    assign empty         = (r_count == '0);
    assign full          = (r_count == c_depth);
    assign top           = r_mem[r_ptr];
    assign overflow_evt  = push & full;
    assign underflow_evt = pop & ~push & empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            r_ptr            <= w_ptr_inc;
            r_mem[w_ptr_inc] <= push_data;
            if (!full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_next_unit.sv
//============================================================================
// Module      : pc_next_unit
// Description : Next-PC selection, run/halt FSM and optional return-address
//               stack (built when PC_NEXT_RAS_EN is defined).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned          BUS_WIDTH    = 16,
    parameter int unsigned          RAS_DEPTH    = 4,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = BUS_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] pc,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 branch_taken,
    input  logic [BUS_WIDTH-1:0] branch_target,
    input  logic                 jump,
    input  logic                 call,
    input  logic [BUS_WIDTH-1:0] jump_target,
    input  logic                 ret,
    output logic [BUS_WIDTH-1:0] pc_next,
    output logic                 halted,
    output logic                 ras_overflow,
    output logic                 ras_underflow
);

    pc_state_t              r_state;
    pc_state_t              w_state_next;
    pc_sel_t                w_sel;
    logic [BUS_WIDTH-1:0]   w_pc_inc;
    logic [BUS_WIDTH-1:0]   w_ret_addr;
    logic                   w_ras_empty;
    logic                   w_push;
    logic                   w_pop;

    generate
        if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("RAS_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    assign w_pc_inc = pc + BUS_WIDTH'(PC_INC);
    assign halted   = (r_state == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HALT is only left through reset
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_RUN && halt && !stall) begin
            w_state_next = ST_HALT;
        end
    end

    always_comb begin
        w_sel = SEL_INC;
        if (rst) begin
            w_sel = SEL_RESET;
        end else if (r_state == ST_HALT || stall) begin
            w_sel = SEL_HOLD;
        end else if (ret) begin
            w_sel = w_ras_empty ? SEL_RET_EMPTY : SEL_RET;
        end else if (call) begin
            w_sel = SEL_CALL;
        end else if (jump) begin
            w_sel = SEL_JUMP;
        end else if (branch_taken) begin
            w_sel = SEL_BRANCH;
        end
    end

    always_comb begin
        pc_next = w_pc_inc;
        case (w_sel)
            SEL_RESET:     pc_next = RESET_VECTOR;
            SEL_HOLD:      pc_next = pc;
            SEL_RET:       pc_next = w_ret_addr;
            SEL_RET_EMPTY: pc_next = w_pc_inc;
            SEL_CALL:      pc_next = jump_target;
            SEL_JUMP:      pc_next = jump_target;
            SEL_BRANCH:    pc_next = branch_target;
            default:       pc_next = w_pc_inc;
        endcase
    end

    // Hold/reset selections never reach these, so stall and HALT suppress stack effects
    assign w_push = (w_sel == SEL_CALL);
    assign w_pop  = (w_sel == SEL_RET) || (w_sel == SEL_RET_EMPTY);

`ifdef PC_NEXT_RAS_EN
    logic [BUS_WIDTH-1:0] w_ras_top;
    logic                 w_ras_full_unused;
    logic                 w_ovf_evt;
    logic                 w_unf_evt;
    logic                 r_ras_overflow;
    logic                 r_ras_underflow;

    ras_stack #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk           (clk),
        .rst           (rst),
        .push          (w_push),
        .pop           (w_pop),
        .push_data     (w_pc_inc),
        .top           (w_ras_top),
        .empty         (w_ras_empty),
        .full          (w_ras_full_unused),
        .overflow_evt  (w_ovf_evt),
        .underflow_evt (w_unf_evt)
    );

    assign w_ret_addr = w_ras_top;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ras_overflow  <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else begin
            r_ras_overflow  <= r_ras_overflow | w_ovf_evt;
            r_ras_underflow <= r_ras_underflow | w_unf_evt;
        end
    end

    assign ras_overflow  = r_ras_overflow;
    assign ras_underflow = r_ras_underflow;
`else
    // Without a stack, returns are register-sourced through jump_target
    logic w_stack_unused;
    assign w_stack_unused = w_push | w_pop;
    assign w_ras_empty    = 1'b0;
    assign w_ret_addr     = jump_target;
    assign ras_overflow   = 1'b0;
    assign ras_underflow  = 1'b0;
`endif

endmodule

`default_nettype wire
